// File: rtl/apb_csr_master.sv
// APB initiator for the ALU CSR slave: one host command at a time becomes a
// SETUP/ACCESS transfer, answered by a one-cycle response pulse.
//
// state  | meaning
// IDLE   | bus parked, cmd_ready high, waiting for a host command
// SETUP  | sel high, en low, address/control/write data presented
// ACCESS | sel and en high, waiting on ready or the timeout
module apb_csr_master #(
    parameter int ADDR_WIDTH     = 3,
    parameter int APB_BUS_SIZE   = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [APB_BUS_SIZE-1:0] cmd_wdata,
    output logic                    rsp_valid,
    output logic [APB_BUS_SIZE-1:0] rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic [ADDR_WIDTH-1:0]   addr,
    output logic                    sel,
    output logic                    en,
    output logic                    write,
    output logic [APB_BUS_SIZE-1:0] wdata,
    input  logic [APB_BUS_SIZE-1:0] rdata,
    input  logic                    ready,
    input  logic                    slv_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // TIMEOUT_CYCLES of zero leaves the transfer waiting on ready forever.
    localparam bit        TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state;
    logic [7:0] to_cnt;
    logic       to_hit;

    assign to_hit = TO_EN && (to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cmd_ready   <= 1'b1;
            sel         <= 1'b0;
            en          <= 1'b0;
            write       <= 1'b0;
            addr        <= '0;
            wdata       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            to_cnt      <= 8'd0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        state     <= SETUP;
                        cmd_ready <= 1'b0;
                        sel       <= 1'b1;
                        en        <= 1'b0;
                        write     <= cmd_write;
                        addr      <= cmd_addr;
                        wdata     <= cmd_wdata;
                    end
                end
                SETUP: begin
                    state  <= ACCESS;
                    en     <= 1'b1;
                    to_cnt <= 8'd0;
                end
                ACCESS: begin
                    // ready wins over a timeout landing in the same cycle
                    if (ready) begin
                        state       <= IDLE;
                        cmd_ready   <= 1'b1;
                        sel         <= 1'b0;
                        en          <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= slv_err;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= (!write && !slv_err) ? rdata : '0;
                    end else if (to_hit) begin
                        state       <= IDLE;
                        cmd_ready   <= 1'b1;
                        sel         <= 1'b0;
                        en          <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    sel       <= 1'b0;
                    en        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_csr_master.sv
// Directed bench for apb_csr_master: hand-computed expectations checked with
// immediate assertions at fixed points after each rising edge.
module tb_apb_csr_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [2:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [2:0]  addr;
    logic        sel;
    logic        en;
    logic        write;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        slv_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb_csr_master #(
        .ADDR_WIDTH    (3),
        .APB_BUS_SIZE  (32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .addr       (addr),
        .sel        (sel),
        .en         (en),
        .write      (write),
        .wdata      (wdata),
        .rdata      (rdata),
        .ready      (ready),
        .slv_err    (slv_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic w, input logic [2:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed time limit expected finish");
        $fatal(1, "watchdog expired");
    end

    logic [2:0]  b_addr  [3];
    logic [31:0] b_wdata [3];
    logic        b_write [3];
    int acc_cyc [3];
    int rsp_cyc [3];

    initial begin
        int acc_cnt;
        int na;
        int nr;
        int k;
        int fl;
        logic acc;

        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rdata = '0; ready = 1'b0; slv_err = 1'b0;
        #12;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_en", 32'(en), 32'd0);
        chk("rst_write", 32'(write), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // write CTRL=1, zero wait states
        ready = 1'b1;
        drive_cmd(1'b1, 3'd0, 32'h1);
        step();
        cmd_valid = 1'b0;
        chk("wr_setup_sel", 32'(sel), 32'd1);
        chk("wr_setup_en", 32'(en), 32'd0);
        chk("wr_setup_write", 32'(write), 32'd1);
        chk("wr_setup_addr", 32'(addr), 32'd0);
        chk("wr_setup_cmd_ready", 32'(cmd_ready), 32'd0);
        step();
        chk("wr_access_sel", 32'(sel), 32'd1);
        chk("wr_access_en", 32'(en), 32'd1);
        chk("wr_access_write", 32'(write), 32'd1);
        chk("wr_access_wdata", wdata, 32'h1);
        chk("wr_access_rsp_valid", 32'(rsp_valid), 32'd0);
        step();
        chk("wr_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("wr_rsp_err", 32'(rsp_err), 32'd0);
        chk("wr_rsp_rdata", rsp_rdata, 32'd0);
        chk("wr_rsp_timeout", 32'(rsp_timeout), 32'd0);
        chk("wr_done_sel", 32'(sel), 32'd0);
        chk("wr_done_en", 32'(en), 32'd0);
        chk("wr_done_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("wr_idle_write_hold", 32'(write), 32'd1);
        step();
        chk("wr_pulse_one_cycle", 32'(rsp_valid), 32'd0);

        // read RES with one wait state
        ready = 1'b0;
        drive_cmd(1'b0, 3'd3, 32'h0);
        step();
        cmd_valid = 1'b0;
        step();
        chk("rd_access1_en", 32'(en), 32'd1);
        chk("rd_access1_write", 32'(write), 32'd0);
        chk("rd_access1_addr", 32'(addr), 32'd3);
        step();
        chk("rd_access2_en", 32'(en), 32'd1);
        chk("rd_access2_rsp_valid", 32'(rsp_valid), 32'd0);
        ready = 1'b1;
        rdata = 32'h00ABCDE;
        step();
        chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rd_rsp_rdata", rsp_rdata, 32'h00ABCDE);
        chk("rd_rsp_err", 32'(rsp_err), 32'd0);
        step();
        chk("rd_rdata_hold", rsp_rdata, 32'h00ABCDE);

        // slave error on read CTRL
        ready = 1'b1; slv_err = 1'b1; rdata = 32'hFFFF_FFFF;
        drive_cmd(1'b0, 3'd0, 32'h0);
        step();
        cmd_valid = 1'b0;
        step();
        step();
        chk("err_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("err_rsp_err", 32'(rsp_err), 32'd1);
        chk("err_rsp_timeout", 32'(rsp_timeout), 32'd0);
        chk("err_rsp_rdata", rsp_rdata, 32'd0);
        slv_err = 1'b0;
        step();

        // timeout: ready never arrives
        ready = 1'b0; rdata = 32'h5555_AAAA;
        drive_cmd(1'b0, 3'd1, 32'h0);
        step();
        cmd_valid = 1'b0;
        step();
        acc_cnt = 0;
        for (int i = 0; i < 40 && en; i++) begin
            chk("to_wait_no_rsp", 32'(rsp_valid), 32'd0);
            acc_cnt++;
            step();
        end
        chk("to_access_cycles", 32'(acc_cnt), 32'd16);
        chk("to_sel", 32'(sel), 32'd0);
        chk("to_en", 32'(en), 32'd0);
        chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("to_rsp_err", 32'(rsp_err), 32'd1);
        chk("to_rsp_timeout", 32'(rsp_timeout), 32'd1);
        chk("to_rsp_rdata", rsp_rdata, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("to_bus_quiet", 32'({sel, en}), 32'd0);
        end

        // back-to-back with cmd_valid held high
        ready = 1'b1; rdata = 32'h0000_1234;
        b_write[0] = 1'b1; b_addr[0] = 3'd1; b_wdata[0] = 32'd5;
        b_write[1] = 1'b1; b_addr[1] = 3'd2; b_wdata[1] = 32'd7;
        b_write[2] = 1'b0; b_addr[2] = 3'd4; b_wdata[2] = 32'd0;
        na = 0; nr = 0; k = 0; fl = 0;
        drive_cmd(b_write[0], b_addr[0], b_wdata[0]);
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (rsp_valid && nr < 3) begin
                rsp_cyc[nr] = cyc;
                nr++;
            end
            if (sel) begin
                chk("b2b_addr", 32'(addr), 32'(b_addr[fl]));
                chk("b2b_wdata", wdata, b_wdata[fl]);
                chk("b2b_write", 32'(write), 32'(b_write[fl]));
            end
            acc = cmd_ready && cmd_valid;
            if (acc) begin
                acc_cyc[na] = cyc;
                na++;
                fl = k;
            end
            step();
            if (acc) begin
                k++;
                if (k < 3) drive_cmd(b_write[k], b_addr[k], b_wdata[k]);
                else cmd_valid = 1'b0;
            end
        end
        chk("b2b_accepts", 32'(na), 32'd3);
        chk("b2b_responses", 32'(nr), 32'd3);
        if (na == 3 && nr == 3) begin
            chk("b2b_acc_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
            chk("b2b_acc_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
            chk("b2b_rsp_gap1", 32'(rsp_cyc[1] - rsp_cyc[0]), 32'd3);
            chk("b2b_rsp_gap2", 32'(rsp_cyc[2] - rsp_cyc[1]), 32'd3);
            chk("b2b_first_latency", 32'(rsp_cyc[0] - acc_cyc[0]), 32'd3);
        end
        chk("b2b_last_rdata", rsp_rdata, 32'h0000_1234);

        // reset in the middle of ACCESS
        ready = 1'b0;
        drive_cmd(1'b0, 3'd2, 32'h0);
        step();
        cmd_valid = 1'b0;
        step();
        chk("rst_mid_en_before", 32'(en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_sel", 32'(sel), 32'd0);
        chk("rst_mid_en", 32'(en), 32'd0);
        chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mid_addr", 32'(addr), 32'd0);
        chk("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
        step();
        rst_n = 1'b1;
        step();
        chk("rst_rel_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rel_cmd_ready", 32'(cmd_ready), 32'd1);
        ready = 1'b1;
        drive_cmd(1'b1, 3'd1, 32'd9);
        step();
        cmd_valid = 1'b0;
        chk("post_rst_setup_sel", 32'(sel), 32'd1);
        step();
        step();
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("post_rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("post_rst_wdata", wdata, 32'd9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_csr_master.md
# apb_csr_master

APB initiator that turns simple command requests from a host-side sequencer into APB transfers towards the ALU control/status register slave. It runs one transfer at a time, inserts the SETUP and ACCESS phases, waits on the slave's ready including wait states, and returns read data and error status as a one-cycle response pulse. A timeout counter ends the transfer if the slave never responds.

## Interface
- ADDR_WIDTH, 3: APB address width. Covers the 5 CSR registers: CTRL=0, DATA0=1, DATA1=2, RES=3, STATUS=4.
- APB_BUS_SIZE, 32: APB data width.
- TIMEOUT_CYCLES, 16: maximum ACCESS cycles before the transfer is aborted. 0 disables the timeout.
- clk  input  1  single clock; all logic updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  host requests a transfer.
- cmd_ready  output  1  block can accept a command; high only in IDLE.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  ADDR_WIDTH  target register address.
- cmd_wdata  input  APB_BUS_SIZE  write data.
- rsp_valid  output  1  one-cycle pulse marking transfer completion.
- rsp_rdata  output  APB_BUS_SIZE  captured read data; 0 for writes, errors and timeouts.
- rsp_err  output  1  slave error or timeout; valid while rsp_valid is high.
- rsp_timeout  output  1  transfer was ended by the timeout; valid while rsp_valid is high.
- addr  output  ADDR_WIDTH  APB address.
- sel  output  1  APB select.
- en  output  1  APB enable.
- write  output  1  APB write.
- wdata  output  APB_BUS_SIZE  APB write data.
- rdata  input  APB_BUS_SIZE  APB read data.
- ready  input  1  APB ready from the slave.
- slv_err  input  1  APB slave error, sampled together with ready.

## Operation
- FSM states and transitions:
  - IDLE → SETUP when cmd_valid && cmd_ready.
  - SETUP → ACCESS unconditionally.
  - ACCESS → IDLE when ready=1, or when the timeout expires.
- On command accept, the block registers cmd_write, cmd_addr and cmd_wdata into write, addr and wdata.
- Output signals per state:
  - SETUP: sel=1, en=0.
  - ACCESS: sel=1, en=1.
  - IDLE: sel=0, en=0.
- addr, write and wdata stay stable from SETUP through the last ACCESS cycle. They keep their last values in IDLE.
- Completion with ready=1 in ACCESS:
  - rsp_err = slv_err.
  - rsp_rdata = rdata when the transfer is a read and slv_err=0; otherwise 0.
  - rsp_timeout = 0.
- Timeout:
  - An 8-bit counter clears on entry to ACCESS and increments on each ACCESS cycle with ready=0.
  - When the counter reaches TIMEOUT_CYCLES-1 while ready=0, the block returns to IDLE.
  - The response is rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - ready=1 in the same cycle takes priority over the timeout.
- rsp_* outputs are registered and hold their values until the next completion. rsp_valid is high for exactly one cycle per transfer.
- cmd_valid outside IDLE is ignored; the command is not accepted. The block never queues more than one command.
- Address range is not checked. Out-of-range addresses go onto the bus, and the slave's error is returned in the response.

## Timing
- Reset values: state=IDLE, cmd_ready=1, sel=0, en=0, write=0, addr=0, wdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, counter=0.
- Transfer accepted at edge N:
  - SETUP during cycle N+1.
  - ACCESS from cycle N+2.
  - With ready=1 in cycle N+2, the edge N+3 completes the transfer: rsp_valid=1 and cmd_ready=1 during cycle N+3.
- Each slave wait state adds one cycle. With zero waits the back-to-back rate is one transfer every 3 cycles.
- A new command may be accepted in the same cycle rsp_valid is high.
- Reset mid-transfer: all outputs immediately go to their reset values, with no rsp_valid; the aborted transfer produces no response.

## Test plan
- Write CTRL: cmd_write=1, addr=0, wdata=0x1, slave ready on the first ACCESS cycle → sel rises one cycle after accept, en one cycle later, write=1 throughout, rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
- Read RES with one wait state: slave ready=0 then 1, rdata=0x00ABCDE → ACCESS lasts 2 cycles, rsp_rdata=0x00ABCDE, rsp_err=0, latency 4 cycles.
- Slave error: read CTRL (addr=0), slave returns ready=1 and slv_err=1, rdata=0xFFFFFFFF → rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- Timeout: TIMEOUT_CYCLES=16, ready held at 0 → exactly 16 ACCESS cycles, then sel=0, en=0, rsp_err=1, rsp_timeout=1; no further bus activity.
- Back-to-back: cmd_valid held high with 3 commands (write DATA0=5, write DATA1=7, read STATUS), zero-wait slave → 3 accepts and 3 rsp_valid pulses spaced 3 cycles apart; addr and wdata stable within each transfer.
- Reset mid-ACCESS: rst_n pulsed low while ready=0 → sel, en and rsp_valid go to 0 immediately with no response pulse; cmd_ready=1 after release; the next command completes normally.
